// File: rtl/ov9281_pkg.sv
// Shared types and defaults for the OV9281 frame writer.
// Holds the writer FSM encoding, default geometry and buffer bases.
// The burst-length field width is derived here so all users agree on it.
package ov9281_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DATA  = 2'd2,
    ST_FDONE = 2'd3
  } wr_state_e;

  // Width of a field that holds 1..bl inclusive.
  function automatic int len_width(input int bl);
    return $clog2(bl) + 1;
  endfunction

  localparam int          DEF_BURST_LEN   = 64;
  localparam int          DEF_LEN_W       = len_width(DEF_BURST_LEN);
  localparam int          DEF_FIFO_DEPTH  = 256;
  localparam int          DEF_ADDR_W      = 28;
  localparam logic [27:0] DEF_BUF0_BASE   = 28'h0000000;
  localparam logic [27:0] DEF_BUF1_BASE   = 28'h0100000;
  localparam int          DEF_FRAME_WORDS = 256000;
  localparam int          FRAME_CNT_W     = 25;

endpackage

// File: rtl/ov9281_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word appears on dout_o one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module ov9281_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; simultaneous push/pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ov9281_frame_writer.sv
// Buffers OV9281 pixel words and writes them to DDR as ping-pong frame bursts.
// Latency: a pushed word reaches wr_data no earlier than one cycle after the push.
// Backpressure: wr_data_ready stalls beats; a full FIFO drops words and flags overflow.
module ov9281_frame_writer
  import ov9281_pkg::*;
#(
  parameter int                BURST_LEN   = DEF_BURST_LEN,
  parameter int                FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BUF0_BASE   = ADDR_W'(DEF_BUF0_BASE),
  parameter logic [ADDR_W-1:0] BUF1_BASE   = ADDR_W'(DEF_BUF1_BASE),
  parameter int                FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                         camera_pclk,
  input  logic                         rst_n,
  input  logic                         camera_vsync,
  input  logic                         camera_wfifo_req,
  input  logic [31:0]                  camera_wfifo_data,
  output logic                         wr_burst_req,
  output logic [ADDR_W-1:0]            wr_burst_addr,
  output logic [$clog2(BURST_LEN):0]   wr_burst_len,
  input  logic                         wr_burst_ack,
  output logic                         wr_data_valid,
  output logic [31:0]                  wr_data,
  input  logic                         wr_data_ready,
  output logic                         frame_done,
  output logic                         done_buf_sel,
  output logic [FRAME_CNT_W-1:0]       frame_words,
  output logic                         frame_err,
  output logic                         ovf_sticky
);

  localparam int LEN_W = len_width(BURST_LEN);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW_W  = FRAME_CNT_W;

  // FIFO interface
  logic [31:0]      fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             fifo_pop;

  // Burst FSM state
  wr_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic             burst_done, fdone;

  // Frame bookkeeping state
  logic              vsync_q;
  logic              eof_evt, sof_evt, sof_any, sof_apply;
  logic              push_ok, drop;
  logic              eof_pend_q, eof_pend_d;
  logic              sof_pend_q, sof_pend_d;
  logic              active_q, active_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [FW_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              frame_ovf_q, frame_ovf_d;
  logic              ovf_sticky_q, ovf_sticky_d;
  logic              frame_done_q;
  logic              done_buf_q, done_buf_d;
  logic [FW_W-1:0]   frame_words_q, frame_words_d;
  logic              frame_err_q, frame_err_d;

  ov9281_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (camera_pclk),
    .rst_n   (rst_n),
    .push_i  (camera_wfifo_req),
    .din_i   (camera_wfifo_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign eof_evt = camera_vsync && !vsync_q;
  assign sof_evt = !camera_vsync && vsync_q;
  assign push_ok = camera_wfifo_req && !fifo_full;
  assign drop    = camera_wfifo_req && fifo_full;

  assign wr_burst_req  = (state_q == ST_REQ);
  assign wr_burst_addr = addr_q;
  assign wr_burst_len  = len_q;
  assign wr_data_valid = (state_q == ST_DATA);
  assign wr_data       = wr_data_valid ? fifo_dout : '0;
  assign frame_done    = frame_done_q;
  assign done_buf_sel  = done_buf_q;
  assign frame_words   = frame_words_q;
  assign frame_err     = frame_err_q;
  assign ovf_sticky    = ovf_sticky_q;

  // Burst FSM: full bursts first, flush the remainder after EOF, then close the frame.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beats_d    = beats_q;
    fifo_pop   = 1'b0;
    burst_done = 1'b0;
    fdone      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count >= CNT_W'(BURST_LEN)) begin
          state_d = ST_REQ;
          len_d   = LEN_W'(BURST_LEN);
        end else if (eof_pend_q && !fifo_empty) begin
          state_d = ST_REQ;
          len_d   = fifo_count[LEN_W-1:0];
        end else if (eof_pend_q) begin
          state_d = ST_FDONE;
        end
      end
      ST_REQ: begin
        if (wr_burst_ack) begin
          state_d = ST_DATA;
          beats_d = len_q;
        end
      end
      ST_DATA: begin
        if (wr_data_ready) begin
          fifo_pop = 1'b1;
          beats_d  = beats_q - LEN_W'(1);
          if (beats_q == LEN_W'(1)) begin
            burst_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_FDONE: begin
        fdone   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: SOF waits until an outstanding EOF has been closed.
  always_comb begin
    sof_any      = sof_evt || sof_pend_q;
    sof_apply    = sof_any && !eof_pend_q;
    sof_pend_d   = sof_any && eof_pend_q;
    eof_pend_d   = eof_evt ? 1'b1 : (fdone ? 1'b0 : eof_pend_q);
    active_d     = fdone ? !active_q : active_q;
    ovf_sticky_d = ovf_sticky_q || drop;

    frame_cnt_d = frame_cnt_q;
    frame_ovf_d = frame_ovf_q || drop;
    addr_d      = addr_q;
    if (sof_apply) begin
      frame_cnt_d = push_ok ? FW_W'(1) : '0;
      frame_ovf_d = drop;
      addr_d      = active_q ? BUF1_BASE : BUF0_BASE;
    end else begin
      if (push_ok) frame_cnt_d = frame_cnt_q + FW_W'(1);
      if (burst_done) addr_d = addr_q + ADDR_W'({len_q, 2'b00});
    end

    done_buf_d    = done_buf_q;
    frame_words_d = frame_words_q;
    frame_err_d   = frame_err_q;
    if (fdone) begin
      done_buf_d    = active_q;
      frame_words_d = frame_cnt_q;
      frame_err_d   = frame_ovf_q || (frame_cnt_q != FW_W'(FRAME_WORDS));
    end
  end

  // FSM registers.
  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beats_q <= beats_d;
    end
  end

  // Frame, address and status registers.
  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      eof_pend_q    <= 1'b0;
      sof_pend_q    <= 1'b0;
      active_q      <= 1'b0;
      addr_q        <= BUF0_BASE;
      frame_cnt_q   <= '0;
      frame_ovf_q   <= 1'b0;
      ovf_sticky_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      done_buf_q    <= 1'b0;
      frame_words_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      vsync_q       <= camera_vsync;
      eof_pend_q    <= eof_pend_d;
      sof_pend_q    <= sof_pend_d;
      active_q      <= active_d;
      addr_q        <= addr_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_ovf_q   <= frame_ovf_d;
      ovf_sticky_q  <= ovf_sticky_d;
      frame_done_q  <= fdone;
      done_buf_q    <= done_buf_d;
      frame_words_q <= frame_words_d;
      frame_err_q   <= frame_err_d;
    end
  end

endmodule
